// File: rtl/axi_ram_cmd_mem.sv
// axi_ram_cmd_mem: single-port RAM backend for the merged AXI RAM command stream.
// Reads return on the response stream one cycle after accept. A two-entry
// output buffer (output register + skid register) absorbs response
// backpressure, so command ready is derived from registered state only.
// Optional feature macro: AXI_RAM_CMD_MEM_CLEAR_EN (zero-fill sweep after reset).
`timescale 1ns/1ps

module axi_ram_cmd_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH/8,
    parameter int ID_WIDTH    = 8,
    parameter int RUSER_WIDTH = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ID_WIDTH-1:0]    i_ram_cmd_id,
    input  logic [ADDR_WIDTH-1:0]  i_ram_cmd_addr,
    input  logic [DATA_WIDTH-1:0]  i_ram_cmd_wr_data,
    input  logic [STRB_WIDTH-1:0]  i_ram_cmd_wr_strb,
    input  logic                   i_ram_cmd_wr_en,
    input  logic                   i_ram_cmd_rd_en,
    input  logic                   i_ram_cmd_last,
    output logic                   o_ram_cmd_ready,
    output logic [ID_WIDTH-1:0]    o_ram_rd_resp_id,
    output logic [DATA_WIDTH-1:0]  o_ram_rd_resp_data,
    output logic                   o_ram_rd_resp_last,
    output logic [RUSER_WIDTH-1:0] o_ram_rd_resp_user,
    output logic                   o_ram_rd_resp_valid,
    input  logic                   i_ram_rd_resp_ready
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int WORDS    = 2**IDX_W;

    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    logic                  r_run;
    logic                  r_out_valid;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic                  r_skid_valid;
    logic [ID_WIDTH-1:0]   r_skid_id;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;

    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_ready;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_pop;
    logic                  w_clr_we;
    logic [IDX_W-1:0]      w_clr_idx;

    assign w_idx     = i_ram_cmd_addr[ADDR_WIDTH-1:ADDR_LSB];
    assign w_rd_word = r_mem[w_idx];

    // Both terms are flops: no combinational path from response ready.
    assign w_ready  = r_run && !r_skid_valid;
    // A simultaneous read+write is treated as a read; the write is dropped.
    assign w_rd_acc = i_ram_cmd_rd_en && w_ready;
    assign w_wr_acc = i_ram_cmd_wr_en && w_ready && !i_ram_cmd_rd_en;
    assign w_pop    = r_out_valid && i_ram_rd_resp_ready;

    generate
        if (ADDR_LSB > 0) begin : g_lsb_unused
            logic w_unused_lsb;
            assign w_unused_lsb = ^i_ram_cmd_addr[ADDR_LSB-1:0];
        end
    endgenerate

`ifdef AXI_RAM_CMD_MEM_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    state_t           r_state;
    logic [IDX_W-1:0] r_clr_idx;

    // Sweep FSM: zero one word per cycle from word 0, then open for commands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_run     <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == {IDX_W{1'b1}}) begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end
                end
                ST_RUN:  r_run <= 1'b1;
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign w_clr_we  = (r_state == ST_CLEAR);
    assign w_clr_idx = r_clr_idx;
`else
    // Run flag rises at the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    assign w_clr_we  = 1'b0;
    assign w_clr_idx = '0;
`endif

    // Array write port: clear sweep or byte-masked command write. Not reset,
    // so contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (i_ram_cmd_wr_strb[i])
                    r_mem[w_idx][i*8 +: 8] <= i_ram_cmd_wr_data[i*8 +: 8];
            end
        end
    end

    // Output register: refills from skid first, else from a new read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_pop || !r_out_valid) begin
            if (r_skid_valid) begin
                r_out_valid <= 1'b1;
                r_out_id    <= r_skid_id;
                r_out_data  <= r_skid_data;
                r_out_last  <= r_skid_last;
            end else if (w_rd_acc) begin
                r_out_valid <= 1'b1;
                r_out_id    <= i_ram_cmd_id;
                r_out_data  <= w_rd_word;
                r_out_last  <= i_ram_cmd_last;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Skid register: catches a read while the output register is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_id    <= '0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_pop) begin
                r_skid_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_skid_id   <= i_ram_cmd_id;
                    r_skid_data <= w_rd_word;
                    r_skid_last <= i_ram_cmd_last;
                end
            end
        end else if (w_rd_acc && r_out_valid && !w_pop) begin
            r_skid_valid <= 1'b1;
            r_skid_id    <= i_ram_cmd_id;
            r_skid_data  <= w_rd_word;
            r_skid_last  <= i_ram_cmd_last;
        end
    end

    assign o_ram_cmd_ready     = w_ready;
    assign o_ram_rd_resp_valid = r_out_valid;
    assign o_ram_rd_resp_id    = r_out_id;
    assign o_ram_rd_resp_data  = r_out_data;
    assign o_ram_rd_resp_last  = r_out_last;
    assign o_ram_rd_resp_user  = '0;

endmodule

// File: tb/tb_axi_ram_cmd_mem.sv
// Bench for axi_ram_cmd_mem (ADDR_WIDTH=8, DATA_WIDTH=32). Expected read
// responses are queued when a read is accepted and compared on pop.
`timescale 1ns/1ps

module tb_axi_ram_cmd_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd_id;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wr_data;
    logic [3:0]  cmd_wr_strb;
    logic        cmd_wr_en;
    logic        cmd_rd_en;
    logic        cmd_last;
    logic        cmd_ready;
    logic [7:0]  resp_id;
    logic [31:0] resp_data;
    logic        resp_last;
    logic [0:0]  resp_user;
    logic        resp_valid;
    logic        resp_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic        last;
    } resp_t;

    resp_t sb_q[$];
    resp_t mon_e;

`ifdef AXI_RAM_CMD_MEM_CLEAR_EN
    localparam int INIT_STALL = 64;
`else
    localparam int INIT_STALL = 1;
`endif

    axi_ram_cmd_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .STRB_WIDTH(4), .ID_WIDTH(8), .RUSER_WIDTH(1)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_ram_cmd_id        (cmd_id),
        .i_ram_cmd_addr      (cmd_addr),
        .i_ram_cmd_wr_data   (cmd_wr_data),
        .i_ram_cmd_wr_strb   (cmd_wr_strb),
        .i_ram_cmd_wr_en     (cmd_wr_en),
        .i_ram_cmd_rd_en     (cmd_rd_en),
        .i_ram_cmd_last      (cmd_last),
        .o_ram_cmd_ready     (cmd_ready),
        .o_ram_rd_resp_id    (resp_id),
        .o_ram_rd_resp_data  (resp_data),
        .o_ram_rd_resp_last  (resp_last),
        .o_ram_rd_resp_user  (resp_user),
        .o_ram_rd_resp_valid (resp_valid),
        .i_ram_rd_resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every response handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got id=%0d data=%h, none expected", resp_id, resp_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (resp_id !== mon_e.id || resp_data !== mon_e.data ||
                    resp_last !== mon_e.last || resp_user !== 1'b0) begin
                    failures++;
                    $display("FAIL resp_payload: got id=%0d data=%h last=%b user=%b, expected id=%0d data=%h last=%b user=0",
                             resp_id, resp_data, resp_last, resp_user, mon_e.id, mon_e.data, mon_e.last);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command, hold until accepted; caller is at posedge+1.
    task automatic do_cmd(input logic wr, input logic rd, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb,
                          input logic [7:0] id, input logic last,
                          input logic [31:0] exp, output int stalls);
        int n = 0;
        cmd_wr_en = wr; cmd_rd_en = rd; cmd_addr = addr;
        cmd_wr_data = wd; cmd_wr_strb = strb; cmd_id = id; cmd_last = last;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        stalls = n;
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout: addr=%h ready=%b after %0d cycles, expected 1", addr, cmd_ready, n);
        end else if (rd) begin
            sb_q.push_back({id, exp, last});
        end
        @(posedge clk); #1;
        cmd_wr_en = 1'b0; cmd_rd_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_ready_after_reset(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            if (!cmd_ready) n++;
        end while (!cmd_ready && n < 200);
        checks++;
        if (n != INIT_STALL) begin
            failures++;
            $display("FAIL %s_ready_delay: ready low for %0d cycles, expected %0d", name, n, INIT_STALL);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; resp_ready = 1'b1;
        cmd_wr_en = 0; cmd_rd_en = 0; cmd_addr = 0; cmd_id = 0;
        cmd_wr_data = 0; cmd_wr_strb = 0; cmd_last = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b, expected 0", cmd_ready);
        end
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b, expected 0", resp_valid);
        end
        checks++;
        if (resp_id !== 8'h0 || resp_data !== 32'h0 || resp_last !== 1'b0 || resp_user !== 1'b0) begin
            failures++;
            $display("FAIL reset_payload: got id=%h data=%h last=%b user=%b, expected all 0",
                     resp_id, resp_data, resp_last, resp_user);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready_after_reset("init");
    endtask

`ifdef AXI_RAM_CMD_MEM_CLEAR_EN
    task automatic test_clear_sweep();
        int s;
        for (int i = 0; i < 64; i++)
            do_cmd(0, 1, 8'(i*4), 0, 0, 8'(i), 1'b0, 32'h0, s);
        drain("clear_sweep");
    endtask
`endif

    task automatic test_write_read();
        int s;
        do_cmd(1, 0, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, s);
        do_cmd(0, 1, 8'h10, 0, 0, 8'd5, 1'b1, 32'hDEADBEEF, s);
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++; $display("FAIL rd_latency: valid=%b one cycle after accept, expected 1", resp_valid);
        end
        drain("write_read");
    endtask

    task automatic test_byte_strobe();
        int s;
        do_cmd(1, 0, 8'h20, 32'h11223344, 4'hF, 0, 0, 0, s);
        do_cmd(1, 0, 8'h20, 32'hAABBCCDD, 4'h5, 0, 0, 0, s);
        do_cmd(0, 1, 8'h22, 0, 0, 8'd6, 1'b0, 32'h11BB33DD, s);
        drain("byte_strobe");
    endtask

    task automatic test_back_to_back();
        int s;
        int total = 0;
        for (int i = 0; i < 8; i++)
            do_cmd(1, 0, 8'(8'h40 + i*4), 32'hA5000000 + i, 4'hF, 0, 0, 0, s);
        for (int i = 0; i < 8; i++) begin
            do_cmd(0, 1, 8'(8'h40 + i*4), 0, 0, 8'(16 + i), 1'(i == 7), 32'hA5000000 + i, s);
            total += s;
        end
        checks++;
        if (total != 0) begin
            failures++; $display("FAIL b2b_throughput: %0d stall cycles, expected 0", total);
        end
        drain("back_to_back");
    endtask

    task automatic test_backpressure();
        logic [7:0]  a[3]  = '{8'h00, 8'h04, 8'h08};
        logic [31:0] ex[3] = '{32'h10000000, 32'h20000004, 32'h30000008};
        int s;
        int idx = 0;
        logic rdy_s = 1'b1;
        logic gap = 1'b0;
        for (int i = 0; i < 3; i++) do_cmd(1, 0, a[i], ex[i], 4'hF, 0, 0, 0, s);
        resp_ready = 1'b0;
        cmd_rd_en = 1'b1; cmd_addr = a[0]; cmd_id = 8'd0; cmd_last = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cmd_ready) begin
                sb_q.push_back({8'(idx), ex[idx], 1'(idx == 2)});
                idx++;
            end
            rdy_s = cmd_ready;
            @(posedge clk); #1;
            if (idx < 3) begin cmd_addr = a[idx]; cmd_id = 8'(idx); cmd_last = 1'(idx == 2); end
            else cmd_rd_en = 1'b0;
        end
        checks++;
        if (idx != 2) begin
            failures++; $display("FAIL bp_accept_count: accepted %0d, expected 2", idx);
        end
        checks++;
        if (rdy_s !== 1'b0) begin
            failures++; $display("FAIL bp_ready_low: ready=%b, expected 0", rdy_s);
        end
        resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 3 && !resp_valid) gap = 1'b1;
            if (cmd_rd_en && cmd_ready) begin
                sb_q.push_back({8'(idx), ex[idx], 1'(idx == 2)});
                idx++;
            end
            @(posedge clk); #1;
            if (idx >= 3) cmd_rd_en = 1'b0;
        end
        checks++;
        if (gap !== 1'b0 || idx != 3) begin
            failures++; $display("FAIL bp_release: gap=%b accepted=%0d, expected gap=0 accepted=3", gap, idx);
        end
        drain("backpressure");
    endtask

    task automatic test_simultaneous();
        int s;
        do_cmd(1, 0, 8'h30, 32'hCAFEF00D, 4'hF, 0, 0, 0, s);
        do_cmd(1, 1, 8'h30, 32'h12345678, 4'hF, 8'd9, 1'b1, 32'hCAFEF00D, s);
        do_cmd(0, 1, 8'h30, 0, 0, 8'd10, 1'b0, 32'hCAFEF00D, s);
        drain("simultaneous");
    endtask

    task automatic test_reset_mid();
        int s;
        resp_ready = 1'b0;
        do_cmd(0, 1, 8'h10, 0, 0, 8'd1, 1'b0, 32'hDEADBEEF, s);
        do_cmd(0, 1, 8'h20, 0, 0, 8'd2, 1'b1, 32'h11BB33DD, s);
        checks++;
        if (resp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL rst_mid_full: valid=%b ready=%b, expected valid=1 ready=0", resp_valid, cmd_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || cmd_ready !== 1'b0 || resp_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_async: valid=%b ready=%b data=%h, expected 0 0 0", resp_valid, cmd_ready, resp_data);
        end
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        wait_ready_after_reset("rst_mid");
`ifdef AXI_RAM_CMD_MEM_CLEAR_EN
        do_cmd(0, 1, 8'h10, 0, 0, 8'd3, 1'b0, 32'h0, s);
        do_cmd(0, 1, 8'h20, 0, 0, 8'd4, 1'b1, 32'h0, s);
`else
        do_cmd(0, 1, 8'h10, 0, 0, 8'd3, 1'b0, 32'hDEADBEEF, s);
        do_cmd(0, 1, 8'h20, 0, 0, 8'd4, 1'b1, 32'h11BB33DD, s);
`endif
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
`ifdef AXI_RAM_CMD_MEM_CLEAR_EN
        test_clear_sweep();
`endif
        test_write_read();
        test_byte_strobe();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
